// File: rtl/hart_ritme_meter.sv
// hart_ritme_meter: windowed heartbeat pulse counter with saturation, refractory filter and rate alarms
//
// Ports:
//   CLK        system clock, all state on the rising edge
//   Reset      synchronous active-high reset
//   Ingang     asynchronous heartbeat pulse input
//   Uitvoer    pulse count of the last completed window
//   Geldig     one-cycle strobe when Uitvoer is refreshed
//   Verzadigd  last completed window saturated the pulse counter
//   Alarm_laag last completed window below ALARM_LO
//   Alarm_hoog last completed window above ALARM_HI
//
// Optional feature macro: HART_RITME_ALARM_EN enables the rate alarm comparators;
// without it Alarm_laag and Alarm_hoog are tied to 0.
module hart_ritme_meter #(
    parameter int CNT_W       = 8,
    parameter int WIN_CYC     = 50000000,
    parameter int REFRACT_CYC = 0,
    parameter int ALARM_LO    = 40,
    parameter int ALARM_HI    = 180
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Ingang,
    output logic [CNT_W-1:0] Uitvoer,
    output logic             Geldig,
    output logic             Verzadigd,
    output logic             Alarm_laag,
    output logic             Alarm_hoog
);
    localparam int WW = $clog2(WIN_CYC);
    localparam int RW = REFRACT_CYC > 0 ? $clog2(REFRACT_CYC + 1) : 1;

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [WW-1:0]    win_q, win_d;
    logic [RW-1:0]    ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic             ovf_q, ovf_d, ovf_nx;
    logic [CNT_W-1:0] uitvoer_q, uitvoer_d;
    logic             geldig_q, geldig_d;
    logic             verz_q, verz_d;
    logic             edge_det, blocked, inc, sat, term;

    always_comb begin
        s1_d      = Ingang;
        s2_d      = s1_q;
        s3_d      = s2_q;
        edge_det  = s2_q & ~s3_q;
        // A nonzero timer means we are still inside the refractory period of the last counted edge.
        blocked   = ref_q != '0;
        inc       = edge_det & ~blocked;
        sat       = &cnt_q;
        cnt_nx    = (inc && !sat) ? cnt_q + 1'b1 : cnt_q;
        // Overflow marks a pulse that arrived while already saturated and was lost.
        ovf_nx    = ovf_q | (inc & sat);
        term      = win_q == WW'(WIN_CYC - 1);
        win_d     = term ? '0 : win_q + 1'b1;
        // Only counted edges reload the timer; it keeps running across windows.
        ref_d     = inc ? RW'(REFRACT_CYC) : (blocked ? ref_q - 1'b1 : ref_q);
        cnt_d     = term ? '0 : cnt_nx;
        ovf_d     = term ? 1'b0 : ovf_nx;
        uitvoer_d = term ? cnt_nx : uitvoer_q;
        verz_d    = term ? ovf_nx : verz_q;
        geldig_d  = term;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            win_q     <= '0;
            ref_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            uitvoer_q <= '0;
            geldig_q  <= 1'b0;
            verz_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            win_q     <= win_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            uitvoer_q <= uitvoer_d;
            geldig_q  <= geldig_d;
            verz_q    <= verz_d;
        end
    end

    assign Uitvoer   = uitvoer_q;
    assign Geldig    = geldig_q;
    assign Verzadigd = verz_q;

`ifdef HART_RITME_ALARM_EN
    logic        laag_q, laag_d, hoog_q, hoog_d;
    logic [31:0] cnt_w;

    always_comb begin
        // Thresholds are compared against the saturated count that is published this window.
        cnt_w  = 32'(cnt_nx);
        laag_d = term ? (cnt_w < 32'(ALARM_LO)) : laag_q;
        hoog_d = term ? (cnt_w > 32'(ALARM_HI)) : hoog_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            laag_q <= 1'b0;
            hoog_q <= 1'b0;
        end else begin
            laag_q <= laag_d;
            hoog_q <= hoog_d;
        end
    end

    assign Alarm_laag = laag_q;
    assign Alarm_hoog = hoog_q;
`else
    assign Alarm_laag = 1'b0;
    assign Alarm_hoog = 1'b0;
`endif
endmodule
